// File: rtl/tc_fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tc_fp_pkg
// Desc     : Shared FP32 constants, rounding-mode encodings and the signed
//            internal exponent type for the tensor-core FP datapath.
// Revision : 1.0 - initial release
// ============================================================================
package tc_fp_pkg;

  // FP32 field geometry
  localparam int FP32_EXP_WIDTH = 8;
  localparam int FP32_MAN_WIDTH = 24;   // includes hidden bit
  localparam int FP32_BIAS      = 127;

  // Exponent carried between stages: two extra bits give headroom for
  // overflow past max-finite and for negative (caller-error) values.
  localparam int EXP_T_WIDTH = FP32_EXP_WIDTH + 2;
  typedef logic signed [EXP_T_WIDTH-1:0] exp_t;

  // Rounding-mode encodings
  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RUP = 3'd2,
    RM_RDN = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

endpackage
`default_nettype wire

// File: rtl/tc_norm_grs_if.sv
`default_nettype none
// ============================================================================
// Module   : tc_norm_grs_if
// Desc     : Valid/ready bundle between the accumulation adder (in_*) and
//            the rounding stage (out_*) around the normalizer.
// Revision : 1.0 - initial release
// ============================================================================
interface tc_norm_grs_if #(
  parameter int IN_WIDTH  = 48,
  parameter int MAN_WIDTH = tc_fp_pkg::FP32_MAN_WIDTH,
  parameter int EXP_WIDTH = tc_fp_pkg::FP32_EXP_WIDTH
);

  // Upstream side
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_sign;
  logic signed [EXP_WIDTH+1:0] in_exp;
  logic [IN_WIDTH-1:0]         in_mant;
  logic                        in_sticky;
  logic [2:0]                  in_rm;

  // Downstream side
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_sign;
  logic signed [EXP_WIDTH+1:0] out_exp;
  logic [MAN_WIDTH-1:0]        out_mant;
  logic                        out_round;
  logic                        out_sticky;
  logic [2:0]                  out_rm;
  logic                        out_zero;

  // Normalizer side
  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_sticky, in_rm, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant, out_round,
           out_sticky, out_rm, out_zero
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_sticky, in_rm, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mant, out_round,
           out_sticky, out_rm, out_zero
  );

endinterface
`default_nettype wire

// File: rtl/tc_lzc.sv
`default_nettype none
// ============================================================================
// Module   : tc_lzc
// Desc     : Combinational leading-zero counter. All-zero input -> WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module tc_lzc #(
  parameter int WIDTH = 48,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  wire logic [WIDTH-1:0] i_data,
  output logic      [CW-1:0]    o_count
);

  // Scan upward; the last set bit seen is the most significant one.
  always_comb begin
    o_count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_count = CW'(WIDTH - 1 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/tc_norm_grs.sv
`default_nettype none
// ============================================================================
// Module   : tc_norm_grs
// Desc     : Two-stage normalizer feeding the rounding stage. Stage 1 latches
//            the adder result and its leading-zero count; stage 2 left-shifts
//            (clamped so the exponent never drops below 1) and extracts the
//            mantissa, round and sticky bits.
// Revision : 1.0 - initial release
// ============================================================================
module tc_norm_grs
  import tc_fp_pkg::*;
#(
  parameter int IN_WIDTH  = 48,
  parameter int MAN_WIDTH = FP32_MAN_WIDTH,
  parameter int EXP_WIDTH = FP32_EXP_WIDTH
) (
  input wire logic       clk,
  input wire logic       rst,
  tc_norm_grs_if.slave   io
);

  localparam int XW  = EXP_WIDTH + 2;
  localparam int LZW = $clog2(IN_WIDTH + 1);
  localparam int CMW = (LZW > XW) ? LZW : XW;
  localparam logic signed [XW-1:0] c_exp_one = XW'(1);

  // Stage 1 registers
  logic                 r_v1;
  logic                 r_sign1;
  logic signed [XW-1:0] r_exp1;
  logic [IN_WIDTH-1:0]  r_mant1;
  logic                 r_sticky1;
  logic [2:0]           r_rm1;
  logic [LZW-1:0]       r_lzc1;

  // Stage 2 registers
  logic                 r_v2;
  logic                 r_sign2;
  logic signed [XW-1:0] r_exp2;
  logic [MAN_WIDTH-1:0] r_mant2;
  logic                 r_round2;
  logic                 r_sticky2;
  logic [2:0]           r_rm2;
  logic                 r_zero2;

  // Handshake and datapath wires
  logic                 w_adv1;
  logic                 w_adv2;
  logic [LZW-1:0]       w_lzc;
  logic                 w_exp_pos;
  logic signed [XW-1:0] w_exp_m1;
  logic [CMW-1:0]       w_clamp;
  logic [CMW-1:0]       w_lzc_ext;
  logic                 w_mant_zero;
  logic [LZW-1:0]       w_shift;
  logic [IN_WIDTH-1:0]  w_n;
  logic signed [XW-1:0] w_exp_out;

  // A stage may load when it is empty or its contents leave this cycle.
  assign w_adv2 = !r_v2 || io.out_ready;
  assign w_adv1 = !r_v1 || w_adv2;

  tc_lzc #(.WIDTH(IN_WIDTH), .CW(LZW)) u_lzc (
    .i_data  (io.in_mant),
    .o_count (w_lzc)
  );

  // Stage 1: capture the incoming beat together with its leading-zero count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_sign1   <= 1'b0;
      r_exp1    <= '0;
      r_mant1   <= '0;
      r_sticky1 <= 1'b0;
      r_rm1     <= '0;
      r_lzc1    <= '0;
    end else if (w_adv1) begin
      r_v1 <= io.in_valid;
      if (io.in_valid) begin
        r_sign1   <= io.in_sign;
        r_exp1    <= io.in_exp;
        r_mant1   <= io.in_mant;
        r_sticky1 <= io.in_sticky;
        r_rm1     <= io.in_rm;
        r_lzc1    <= w_lzc;
      end
    end
  end

  // Shift amount: full normalization unless that would push the exponent
  // below 1, in which case stop at exponent 1 and flag subnormal (exp 0).
  always_comb begin
    w_exp_pos   = (r_exp1 >= c_exp_one);
    w_exp_m1    = r_exp1 - c_exp_one;
    w_clamp     = w_exp_pos ? CMW'($unsigned(w_exp_m1)) : '0;
    w_lzc_ext   = CMW'(r_lzc1);
    w_mant_zero = (r_mant1 == '0);
    if (w_mant_zero)              w_shift = '0;
    else if (w_lzc_ext <= w_clamp) w_shift = r_lzc1;
    else                           w_shift = LZW'(w_clamp);
    w_n       = r_mant1 << w_shift;
    w_exp_out = (w_n[IN_WIDTH-1] && w_exp_pos) ? (r_exp1 - XW'(w_shift)) : '0;
  end

  // Stage 2: register the normalized fields; hold while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2      <= 1'b0;
      r_sign2   <= 1'b0;
      r_exp2    <= '0;
      r_mant2   <= '0;
      r_round2  <= 1'b0;
      r_sticky2 <= 1'b0;
      r_rm2     <= '0;
      r_zero2   <= 1'b0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_sign2   <= r_sign1;
        r_exp2    <= w_exp_out;
        r_mant2   <= w_n[IN_WIDTH-1 -: MAN_WIDTH];
        r_round2  <= w_n[IN_WIDTH-MAN_WIDTH-1];
        r_sticky2 <= (|w_n[IN_WIDTH-MAN_WIDTH-2:0]) | r_sticky1;
        r_rm2     <= r_rm1;
        r_zero2   <= w_mant_zero;
      end
    end
  end

  assign io.in_ready   = w_adv1;
  assign io.out_valid  = r_v2;
  assign io.out_sign   = r_sign2;
  assign io.out_exp    = r_exp2;
  assign io.out_mant   = r_mant2;
  assign io.out_round  = r_round2;
  assign io.out_sticky = r_sticky2;
  assign io.out_rm     = r_rm2;
  assign io.out_zero   = r_zero2;

endmodule
`default_nettype wire

// File: tb/tb_tc_norm_grs.sv
`default_nettype none
// ============================================================================
// Module   : tb_tc_norm_grs
// Desc     : Self-checking bench for tc_norm_grs with a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tc_norm_grs;
  import tc_fp_pkg::*;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] mant;
    logic        round;
    logic        sticky;
    logic [2:0]  rm;
    logic        zero;
  } exp_s;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_s q[$];
  exp_s mon_got;
  exp_s mon_exp;
  exp_s bp_e[4];
  logic [47:0] bp_m[4];

  always #5 clk = ~clk;

  tc_norm_grs_if #(.IN_WIDTH(48), .MAN_WIDTH(24), .EXP_WIDTH(8)) ifc ();

  tc_norm_grs #(.IN_WIDTH(48), .MAN_WIDTH(24), .EXP_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc.slave)
  );

  function automatic exp_s cur_out();
    exp_s r;
    r = '{sign: ifc.out_sign, exp: ifc.out_exp, mant: ifc.out_mant,
          round: ifc.out_round, sticky: ifc.out_sticky, rm: ifc.out_rm,
          zero: ifc.out_zero};
    return r;
  endfunction

  // Reference: normalize one bit at a time until the MSB is set or the
  // exponent reaches 1.
  function automatic exp_s model(input logic s, input logic signed [9:0] ex,
                                 input logic [47:0] m, input logic st,
                                 input logic [2:0] rm);
    exp_s        r;
    logic [47:0] n;
    int          e;
    n = m;
    e = int'(ex);
    if (n != 48'd0) begin
      while (!n[47] && e > 1) begin
        n = n << 1;
        e = e - 1;
      end
    end
    r.sign   = s;
    r.exp    = (n[47] && e >= 1) ? 10'(e) : 10'd0;
    r.mant   = n[47:24];
    r.round  = n[23];
    r.sticky = (|n[22:0]) | st;
    r.rm     = rm;
    r.zero   = (m == 48'd0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Call at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic send(input exp_s e, input logic s, input logic [9:0] ex,
                      input logic [47:0] m, input logic st, input logic [2:0] rm);
    bit rdy;
    int cnt;
    ifc.in_valid  = 1'b1;
    ifc.in_sign   = s;
    ifc.in_exp    = ex;
    ifc.in_mant   = m;
    ifc.in_sticky = st;
    ifc.in_rm     = rm;
    rdy = 1'b0;
    cnt = 0;
    while (!rdy && cnt < 300) begin
      @(negedge clk);
      rdy = ifc.in_ready;
      @(posedge clk);
      #1;
      cnt++;
    end
    if (rdy) q.push_back(e);
    else begin
      n_tests++;
      n_fail++;
      $error("FAIL send_timeout observed=in_ready_low expected=accept");
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic send_m(input logic s, input logic [9:0] ex, input logic [47:0] m,
                        input logic st, input logic [2:0] rm);
    send(model(s, ex, m, st, rm), s, ex, m, st, rm);
  endtask

  // Scoreboard: every transferred output beat is compared in order.
  always @(negedge clk) begin
    if (!rst && ifc.out_valid && ifc.out_ready) begin
      mon_got = cur_out();
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $error("FAIL sb_unexpected observed=%h expected=none", mon_got);
      end else begin
        mon_exp = q.pop_front();
        assert (mon_got === mon_exp) else begin
          n_fail++;
          $error("FAIL sb_beat observed=%h expected=%h", mon_got, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_sign   = 1'b0;
    ifc.in_exp    = '0;
    ifc.in_mant   = '0;
    ifc.in_sticky = 1'b0;
    ifc.in_rm     = '0;
    ifc.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_in_ready",  64'(ifc.in_ready),  64'd1);
    chk("rst_out_data",  64'(cur_out()),     64'd0);
    @(posedge clk); #1;

    // Directed vectors with hand-derived expectations
    send('{sign:0, exp:10'd130, mant:24'h800000, round:0, sticky:0, rm:0, zero:0},
         1'b0, 10'd130, 48'h8000_0000_0000, 1'b0, 3'd0);
    send('{sign:0, exp:10'd107, mant:24'hC00000, round:1, sticky:0, rm:1, zero:0},
         1'b0, 10'd130, 48'h0000_0180_0001, 1'b0, 3'd1);
    send('{sign:1, exp:10'd107, mant:24'hC00000, round:1, sticky:1, rm:2, zero:0},
         1'b1, 10'd130, 48'h0000_0180_0001, 1'b1, 3'd2);
    send('{sign:0, exp:10'd0, mant:24'h000200, round:0, sticky:0, rm:0, zero:0},
         1'b0, 10'd10, 48'h0000_0100_0000, 1'b0, 3'd0);
    send('{sign:1, exp:10'd0, mant:24'h000000, round:0, sticky:0, rm:3, zero:1},
         1'b1, 10'd100, 48'h0, 1'b0, 3'(RM_RDN));
    send('{sign:0, exp:10'd0, mant:24'h000000, round:0, sticky:1, rm:4, zero:1},
         1'b0, 10'd5, 48'h0, 1'b1, 3'd4);
    // Caller error: exponent below 1 -> no shift, exponent forced to 0
    send('{sign:0, exp:10'd0, mant:24'h800000, round:0, sticky:0, rm:0, zero:0},
         1'b0, 10'd0, 48'h8000_0000_0000, 1'b0, 3'd0);
    send('{sign:0, exp:10'd0, mant:24'h000000, round:0, sticky:1, rm:0, zero:0},
         1'b0, 10'h3FD, 48'h0000_0000_0001, 1'b0, 3'd0);
    // Exponent overflow passes through unchanged
    send('{sign:0, exp:10'd300, mant:24'h800001, round:1, sticky:1, rm:0, zero:0},
         1'b0, 10'd300, 48'h8000_0180_0001, 1'b0, 3'd0);
    repeat (4) @(posedge clk); #1;
    chk("drain_directed", 64'(q.size()), 64'd0);

    // Backpressure: 4 beats with out_ready low for 6 cycles
    for (int i = 0; i < 4; i++) begin
      bp_m[i] = 48'h0000_0F00_0000 << (i * 3);
      bp_e[i] = model(1'(i), 10'd140, bp_m[i], 1'b0, 3'(i));
    end
    ifc.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(bp_e[i], 1'(i), 10'd140, bp_m[i], 1'b0, 3'(i));
      end
      begin
        for (int c = 0; c < 6; c++) begin
          @(negedge clk);
          if (c >= 2) begin
            chk("bp_out_valid", 64'(ifc.out_valid), 64'd1);
            chk("bp_in_ready",  64'(ifc.in_ready),  64'd0);
            chk("bp_hold",      64'(cur_out()),     64'(bp_e[0]));
          end
        end
        @(posedge clk); #1;
        ifc.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          chk("bp_stream_valid", 64'(ifc.out_valid), 64'd1);
        end
      end
    join
    repeat (4) @(posedge clk); #1;
    chk("drain_bp", 64'(q.size()), 64'd0);

    // Asynchronous reset with both stages full
    ifc.out_ready = 1'b0;
    send_m(1'b0, 10'd120, 48'h0000_1234_5678, 1'b0, 3'd0);
    send_m(1'b1, 10'd121, 48'h0ABC_0000_0001, 1'b1, 3'd1);
    @(negedge clk);
    chk("ar_full_valid", 64'(ifc.out_valid), 64'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("ar_valid_drop", 64'(ifc.out_valid), 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    ifc.out_ready = 1'b1;
    #1 chk("ar_in_ready", 64'(ifc.in_ready), 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("ar_no_stale", 64'(ifc.out_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Random beats under random backpressure
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          logic [63:0] t;
          logic [47:0] m;
          logic [9:0]  ex;
          t  = {$urandom(), $urandom()};
          m  = t[47:0] >> $urandom_range(0, 48);
          if ($urandom_range(0, 9) == 0) m = 48'd0;
          ex = 10'(int'($urandom_range(0, 305)) - 3);
          send_m(1'($urandom()), ex, m, 1'($urandom()), 3'($urandom_range(0, 4)));
        end
      end
      begin
        for (int c = 0; c < 80; c++) begin
          @(posedge clk); #1;
          ifc.out_ready = ($urandom_range(0, 3) != 0);
        end
        ifc.out_ready = 1'b1;
      end
    join
    ifc.out_ready = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("drain_random", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tc_norm_grs.md
Name: tc_norm_grs

Overview:
- Producer end of the rounding interface: converts a wide, unnormalized adder-tree result into mantissa/round/sticky/sign/rm fields for the downstream combinational rounding stage.
- Sits between the tensor-core accumulation adder and the rounding and packing logic.
- Two-stage valid/ready pipeline:
  - Stage 1 registers the input and computes the leading-zero count.
  - Stage 2 applies a left shift with subnormal clamp and extracts the guard/round and sticky bits.

Parameters:
IN_WIDTH, 48, width of unnormalized input magnitude
MAN_WIDTH, 24, output mantissa width incl. hidden bit (matches rounding WIDTH)
EXP_WIDTH, 8, IEEE biased exponent width; internal/output exponent is EXP_WIDTH+2 bits signed

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept input
in_sign  input  1  result sign
in_exp  input  EXP_WIDTH+2  signed biased exponent of bit IN_WIDTH-1 of in_mant
in_mant  input  IN_WIDTH  unsigned magnitude
in_sticky  input  1  sticky from earlier alignment shifts
in_rm  input  3  rounding mode, passed through
out_valid  output  1  output beat valid
out_ready  input  1  consumer accepts output
out_sign  output  1  sign
out_exp  output  EXP_WIDTH+2  normalized biased exponent; 0 = subnormal/zero
out_mant  output  MAN_WIDTH  feeds rounding "in"
out_round  output  1  feeds rounding "roundin"
out_sticky  output  1  feeds rounding "stickyin"
out_rm  output  3  feeds rounding "rm"
out_zero  output  1  input magnitude was zero

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all valids 0; all registered data (out_* and stage-1 registers) 0. in_ready reads 1 after reset.
- Reset mid-operation: rst asserted with either stage full drops out_valid in the same instant; in-flight beats are discarded and nothing is replayed.
- Handshake:
  - A beat transfers on valid && ready.
  - Stage k advances when it is empty or the stage after it is consumed.
  - in_ready = !v1 || !v2 || out_ready. out_ready does not depend on out_valid.
  - Full throughput: one beat per cycle.
  - Latency: exactly 2 cycles from input accept to out_valid, when there is no backpressure.
  - While out_valid && !out_ready, all out_* hold stable. Order is preserved.
- Stage 1 registers sign, exp, mant, sticky and rm, plus lzc = leading zeros of in_mant (0..IN_WIDTH).
- Stage 2:
  - shift = min(lzc, max(exp-1, 0)); if mant==0, shift = 0.
  - n = mant << shift.
  - out_mant = n[IN_WIDTH-1 -: MAN_WIDTH].
  - out_round = n[IN_WIDTH-MAN_WIDTH-1].
  - out_sticky = |n[IN_WIDTH-MAN_WIDTH-2:0] | sticky.
  - out_exp = n[IN_WIDTH-1] ? exp-shift : 0 (subnormal clamp).
  - out_zero = (mant==0); when set, out_exp = 0, out_mant = 0, out_round = 0, and out_sticky = sticky.
- in_exp < 1 with nonzero mant is a caller error. The required response is shift = 0 and out_exp = 0; no right shift is done.
- Exponent overflow (out_exp above max finite) is passed through unchanged; the pack stage handles it.
- Sign and rm are pure pass-through, delayed 2 stages.

Decomposition:
- Shared package tc_fp_pkg holds:
  - FP32 constants: EXP_WIDTH=8, MAN_WIDTH=24, bias 127.
  - Rounding-mode encodings: RNE=0, RTZ=1, RUP=2, RDN=3, RMM=4.
  - Width of the signed exponent type.
- One sub-module, tc_lzc: parameterized combinational leading-zero counter (width IN_WIDTH, output $clog2(IN_WIDTH+1) bits, all-zero input -> IN_WIDTH).

Test Plan:
- Normal, already normalized: in_mant=48'h8000_0000_0000, in_exp=130, sticky=0 -> 2 cycles later out_mant=24'h800000, round=0, sticky=0, out_exp=130, zero=0.
- Normalize with round bit: in_mant=48'h0000_0180_0001, in_exp=130 -> lzc=23, out_mant=24'hC00000, round=1, sticky=0, out_exp=107. Same with in_sticky=1 -> out_sticky=1.
- Subnormal clamp: in_mant=48'h0000_0100_0000, in_exp=10 -> shift=9, out_mant=24'h000200, round=0, sticky=0, out_exp=0.
- Zero input: in_mant=0, in_exp=100, in_sign=1, rm=3 -> out_zero=1, out_mant=0, out_exp=0, out_sign=1, out_rm=3.
- Backpressure: stream 4 beats with out_ready=0 for 6 cycles.
  - in_ready drops after 2 accepted.
  - Outputs stay frozen on beat 0.
  - On out_ready=1, all 4 beats emerge in order, one per cycle.
- Async reset: assert rst mid-cycle with both stages full -> out_valid=0 immediately. After release, in_ready=1 and no stale beat appears.
